line_buffer77: RTL and testbench

Raster-to-column line buffer sitting directly upstream of the 7x7 convolution stage. It accepts one pixel per `pix_valid` cycle in row-major order and stores the six previous image lines. For each accepted pixel it presents the seven vertically aligned pixels of the current column, plus a shift enable, to the convolution window. It also flags when the downstream 7x7 window holds a complete, in-image window.

---
 rtl/conv_pkg.sv | 12 +
 rtl/line_mem.sv | 23 ++
 rtl/line_buffer77.sv | 123 ++++++++++++
 tb/tb_line_buffer77.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared parameters for the 7x7 line buffer and convolution stage.
package conv_pkg;

  localparam int unsigned KSIZE         = 7;
  localparam int unsigned BIT_WIDTH_DEF = 8;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_mem.sv
// One image line of storage: single port, asynchronous read, so the old
// word at the address is seen in the same cycle it is overwritten.
module line_mem #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_c = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/line_buffer77.sv
// Raster-to-column line buffer feeding the 7x7 convolution window: six
// line memories, position counters, masked column outputs and window valid.
module line_buffer77
  import conv_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pix_valid,
  input  logic signed [BIT_WIDTH-1:0] pix_in,
  output logic signed [BIT_WIDTH-1:0] row1,
  output logic signed [BIT_WIDTH-1:0] row2,
  output logic signed [BIT_WIDTH-1:0] row3,
  output logic signed [BIT_WIDTH-1:0] row4,
  output logic signed [BIT_WIDTH-1:0] row5,
  output logic signed [BIT_WIDTH-1:0] row6,
  output logic signed [BIT_WIDTH-1:0] row7,
  output logic                        en_out,
  output logic                        win_valid,
  output logic                        frame_done
);

  localparam int unsigned COL_W  = cnt_width(IMG_WIDTH);
  localparam int unsigned ROW_W  = cnt_width(IMG_HEIGHT);
  localparam int unsigned NLINES = KSIZE - 1;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] line_q, line_d;
  logic [BIT_WIDTH-1:0] pix_q [KSIZE];
  logic [BIT_WIDTH-1:0] pix_d [KSIZE];
  logic [BIT_WIDTH-1:0] wr_c [NLINES];
  logic [BIT_WIDTH-1:0] rd_c [NLINES];
  logic en_q, win_pend_q, win_pend_d, win_q, fd_q, fd_d;
  logic last_col_c, last_line_c, mem_we_c;

  assign last_col_c  = (col_q == COL_W'(IMG_WIDTH - 1));
  assign last_line_c = (line_q == ROW_W'(IMG_HEIGHT - 1));
  assign mem_we_c    = pix_valid & ~rst;

  // Line k+1 is fed from line k's pre-write value: a vertical shift per column.
  assign wr_c[0] = pix_in;
  for (genvar k = 1; k < NLINES; k++) begin : g_chain
    assign wr_c[k] = rd_c[k-1];
  end

  for (genvar k = 0; k < NLINES; k++) begin : g_mem
    line_mem #(
      .DEPTH  (IMG_WIDTH),
      .WIDTH  (BIT_WIDTH),
      .ADDR_W (COL_W)
    ) u_line_mem (
      .clk     (clk),
      .we_i    (mem_we_c),
      .addr_i  (col_q),
      .wdata_i (wr_c[k]),
      .rdata_c (rd_c[k])
    );
  end

  // Raster position counters.
  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (pix_valid) begin
      if (last_col_c) begin
        col_d  = '0;
        line_d = last_line_c ? '0 : line_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Column outputs; lines above the top of the current frame read as zero.
  always_comb begin
    pix_d = pix_q;
    if (pix_valid) begin
      pix_d[KSIZE-1] = pix_in;
      for (int unsigned k = 1; k < KSIZE; k++) begin
        pix_d[KSIZE-1-k] = (32'(line_q) >= k) ? rd_c[k-1] : '0;
      end
    end
  end

  assign win_pend_d = pix_valid && (line_q >= ROW_W'(KSIZE - 1))
                                && (col_q  >= COL_W'(KSIZE - 1));
  assign fd_d       = pix_valid && last_col_c && last_line_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      line_q     <= '0;
      pix_q      <= '{default: '0};
      en_q       <= 1'b0;
      win_pend_q <= 1'b0;
      win_q      <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      col_q      <= col_d;
      line_q     <= line_d;
      pix_q      <= pix_d;
      en_q       <= pix_valid;
      win_pend_q <= win_pend_d;
      win_q      <= win_pend_q;
      fd_q       <= fd_d;
    end
  end

  assign row1       = pix_q[0];
  assign row2       = pix_q[1];
  assign row3       = pix_q[2];
  assign row4       = pix_q[3];
  assign row5       = pix_q[4];
  assign row6       = pix_q[5];
  assign row7       = pix_q[6];
  assign en_out     = en_q;
  assign win_valid  = win_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_line_buffer77.sv
// Randomized bench for line_buffer77 on an 8x8 image, checked against an
// image-array reference model of the column/mask/window rules.
module tb_line_buffer77;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int BW = 8;
  localparam int WINS_PER_FRAME = (W - 6) * (H - 6);

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid;
  logic [BW-1:0] pix_in;
  logic [BW-1:0] row1, row2, row3, row4, row5, row6, row7;
  logic          en_out, win_valid, frame_done;

  line_buffer77 #(
    .BIT_WIDTH  (BW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .row1       (row1),
    .row2       (row2),
    .row3       (row3),
    .row4       (row4),
    .row5       (row5),
    .row6       (row6),
    .row7       (row7),
    .en_out     (en_out),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the current frame as an image plus a raster position.
  logic [BW-1:0] img [H][W];
  int            m_r, m_c;
  logic [55:0]   exp_rows;
  logic          exp_en, exp_win, exp_fd, win_pend;
  int            n_acc, n_win, n_fd;
  logic          pat_mode;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [BW-1:0] p, input logic r_in);
    logic dir66;
    dir66     = 1'b0;
    pix_valid = v;
    pix_in    = p;
    rst       = r_in;
    @(posedge clk);
    if (r_in) begin
      m_r = 0; m_c = 0;
      exp_en = 1'b0; exp_win = 1'b0; exp_fd = 1'b0; win_pend = 1'b0;
      exp_rows = '0;
    end else begin
      exp_win  = win_pend;
      win_pend = v && (m_r >= 6) && (m_c >= 6);
      exp_en   = v;
      exp_fd   = v && (m_r == H - 1) && (m_c == W - 1);
      if (v) begin
        dir66 = pat_mode && (m_r == 6) && (m_c == 6);
        img[m_r][m_c] = p;
        for (int n = 1; n <= 7; n++) begin
          int k;
          k = 7 - n;
          exp_rows[(7-n)*8 +: 8] = (m_r >= k) ? img[m_r-k][m_c] : 8'h00;
        end
        n_acc++;
        if (m_c == W - 1) begin
          m_c = 0;
          m_r = (m_r == H - 1) ? 0 : m_r + 1;
        end else begin
          m_c = m_c + 1;
        end
      end
    end
    #1;
    check("rows", 64'({row1, row2, row3, row4, row5, row6, row7}), 64'(exp_rows));
    check("en_out", 64'(en_out), 64'(exp_en));
    check("win_valid", 64'(win_valid), 64'(exp_win));
    check("frame_done", 64'(frame_done), 64'(exp_fd));
    if (dir66)
      check("col_6_6", 64'({row1, row2, row3, row4, row5, row6, row7}), 64'h06_16_26_36_46_56_66);
    if (win_valid === 1'b1) n_win++;
    if (frame_done === 1'b1) n_fd++;
  endtask

  function automatic logic [BW-1:0] pat_pix();
    return BW'(16 * m_r + m_c);
  endfunction

  // mode 0: continuous pattern, 1: alternating valid pattern, 2: random.
  task automatic run_frames(input int nframes, input int mode);
    int   target;
    logic v;
    target   = n_acc + nframes * W * H;
    n_win    = 0;
    n_fd     = 0;
    pat_mode = (mode != 2);
    v        = 1'b1;
    while (n_acc < target) begin
      if (mode == 2) v = ($urandom_range(0, 9) < 7);
      step(v, (mode == 2) ? BW'($urandom) : pat_pix(), 1'b0);
      if (mode == 1) v = ~v;
    end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check("win_count", 64'(n_win), 64'(nframes * WINS_PER_FRAME));
    check("fd_count", 64'(n_fd), 64'(nframes));
  endtask

  initial begin
    n_acc    = 0;
    pat_mode = 1'b1;
    m_r      = 0;
    m_c      = 0;
    win_pend = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    rst       = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step(1'b1, BW'($urandom), 1'b1);

    run_frames(2, 0);
    run_frames(1, 1);
    run_frames(3, 2);

    // Reset mid-frame with a pixel presented alongside it.
    pat_mode = 1'b1;
    while (!(m_r == 4 && m_c == 2)) step(1'b1, pat_pix(), 1'b0);
    step(1'b1, pat_pix(), 1'b1);

    // Reset right after (6,6): its pending window must be dropped.
    while (!(m_r == 6 && m_c == 6)) step(1'b1, pat_pix(), 1'b0);
    step(1'b1, pat_pix(), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check("win_dropped", 64'(win_valid), 64'(0));

    run_frames(1, 0);
    run_frames(1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
